// File: rtl/lbp_pkg.sv
// Shared constants and FSM encoding for the LBP histogram block.
// Image geometry helpers live here so the border test is defined once.
package lbp_pkg;

  localparam int IMG_W       = 128;
  localparam int BINS        = 256;
  localparam int PIX_CNT_DEF = 15876;
  localparam int TOT_W       = 14;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] EDGE_LO = 7'd0;
  localparam logic [6:0] EDGE_HI = 7'(IMG_W - 1);

  // Address is row*128+col; a result on the outer ring cannot come from a full 3x3 window.
  function automatic logic on_border(input logic [13:0] addr);
    logic [6:0] row;
    logic [6:0] col;
    row = addr[13:7];
    col = addr[6:0];
    return (row == EDGE_LO) || (row == EDGE_HI) || (col == EDGE_LO) || (col == EDGE_HI);
  endfunction

endpackage

// File: rtl/lbp_hist.sv
// 256-bin LBP code histogram: accumulate strobes, then drain one bin per accepted beat.
// Beats appear one cycle after finish; hist_bin/hist_count hold while hist_ready is low.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int PIX_CNT = PIX_CNT_DEF,
  parameter int CNT_W   = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic             cnt_ok,
  output logic             err
);

  localparam logic [CNT_W-1:0] BIN_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_EXP = TOT_W'(PIX_CNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bins_q [BINS];
  logic [CNT_W-1:0] bins_d [BINS];
  logic [7:0]       idx_q, idx_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    bins_d  = bins_q;
    idx_d   = idx_q;
    total_d = total_q;
    err_d   = err_q;

    // Protocol errors are only flagged; counting still follows the state.
    if (lbp_valid) begin
      if (on_border(lbp_addr)) err_d = 1'b1;
      if (state_q != ACCUM)    err_d = 1'b1;
    end

    case (state_q)
      ACCUM: begin
        if (lbp_valid) begin
          if (bins_q[lbp_data] == BIN_MAX) err_d = 1'b1;
          else bins_d[lbp_data] = bins_q[lbp_data] + 1'b1;
          if (total_q == TOT_MAX) err_d = 1'b1;
          else total_d = total_q + 1'b1;
        end
        if (finish) state_d = DRAIN;
      end
      DRAIN: begin
        if (hist_ready) begin
          bins_d[idx_q] = '0;
          idx_d         = idx_q + 8'd1;
          if (idx_q == 8'hFF) state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < BINS; i++) bins_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      err_q   <= err_d;
      bins_q  <= bins_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign hist_valid = (state_q == DRAIN);
  assign hist_bin   = hist_valid ? idx_q : 8'd0;
  assign hist_count = hist_valid ? bins_q[idx_q] : '0;
  assign hist_done  = (state_q == DONE);
  assign cnt_ok     = hist_done && (total_q == TOT_EXP);
  assign err        = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Randomized scoreboard bench for lbp_hist against an array-based histogram model.
// Stimulus pushes expected beats at finish; a negedge monitor pops and compares them.
module tb_lbp_hist;
  import lbp_pkg::*;

  localparam int PIX = 15876;
  localparam int CW  = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          lbp_valid = 1'b0;
  logic [13:0]   lbp_addr = '0;
  logic [7:0]    lbp_data = '0;
  logic          finish = 1'b0;
  logic          hist_ready = 1'b1;
  logic          hist_valid;
  logic [7:0]    hist_bin;
  logic [CW-1:0] hist_count;
  logic          hist_done;
  logic          cnt_ok;
  logic          err;

  always #5 clk = ~clk;

  lbp_hist #(.PIX_CNT(PIX), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_done  (hist_done),
    .cnt_ok     (cnt_ok),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;
  int exp_bin_q[$];
  int exp_cnt_q[$];
  int model_bins[256];
  int model_total = 0;
  bit model_err = 0;
  int beat_cnt = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int interior_addr(input int i);
    return (1 + i / 126) * IMG_W + (1 + i % 126);
  endfunction

  function automatic bit is_border(input int addr);
    int row, col;
    row = addr / IMG_W;
    col = addr % IMG_W;
    return (row == 0) || (row == IMG_W - 1) || (col == 0) || (col == IMG_W - 1);
  endfunction

  // LBP code of a pixel: bit k set when neighbour k is >= centre.
  function automatic logic [7:0] lbp_of(input int c, input int nb[8]);
    logic [7:0] code;
    code = '0;
    for (int k = 0; k < 8; k++) code[k] = (nb[k] >= c);
    return code;
  endfunction

  task automatic push_expected();
    for (int b = 0; b < 256; b++) begin
      exp_bin_q.push_back(b);
      exp_cnt_q.push_back(model_bins[b]);
    end
  endtask

  task automatic strobe(input logic [7:0] code, input int addr, input bit fin);
    lbp_valid = 1'b1;
    lbp_data  = code;
    lbp_addr  = addr[13:0];
    if (model_bins[code] < (1 << CW) - 1) model_bins[code]++;
    if (model_total < (1 << TOT_W) - 1) model_total++;
    if (is_border(addr)) model_err = 1;
    if (fin) begin
      finish = 1'b1;
      push_expected();
    end
    @(posedge clk); #1;
    lbp_valid = 1'b0;
  endtask

  task automatic finish_alone();
    finish = 1'b1;
    push_expected();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst_valid", hist_valid, 0);
    check("rst_bin", hist_bin, 0);
    check("rst_count", hist_count, 0);
    check("rst_done", hist_done, 0);
    check("rst_cnt_ok", cnt_ok, 0);
    check("rst_err", err, 0);
    exp_bin_q.delete();
    exp_cnt_q.delete();
    foreach (model_bins[b]) model_bins[b] = 0;
    model_total = 0;
    model_err   = 0;
    beat_cnt    = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int inject);
    int left;
    left = inject;
    for (int c = 0; c < 4000; c++) begin
      lbp_valid = 1'b0;
      if (hist_done) break;
      if (left > 0 && hist_valid && c > 5) begin
        lbp_valid = 1'b1;
        lbp_data  = 8'($urandom_range(0, 255));
        lbp_addr  = interior_addr($urandom_range(0, PIX - 1));
        model_err = 1;
        left--;
      end
      @(posedge clk); #1;
    end
    lbp_valid = 1'b0;
    check({name, "_done"}, hist_done, 1);
    check({name, "_cnt_ok"}, cnt_ok, int'(model_total == PIX));
    check({name, "_err"}, err, int'(model_err));
    check({name, "_valid_off"}, hist_valid, 0);
    check({name, "_queue_empty"}, exp_bin_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       hist_ready = 1'b1;
        1:       hist_ready = ~hist_ready;
        default: hist_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit stall;
    int sbin, scnt, eb, ec;
    stall = 0;
    sbin = 0;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 0;
        continue;
      end
      if (hist_valid) begin
        if (stall) begin
          check("stable_bin", hist_bin, sbin);
          check("stable_count", hist_count, scnt);
        end
        if (hist_ready) begin
          check("beat_expected", int'(exp_bin_q.size() > 0), 1);
          if (exp_bin_q.size() > 0) begin
            eb = exp_bin_q.pop_front();
            ec = exp_cnt_q.pop_front();
            check("beat_bin", hist_bin, eb);
            check("beat_count", hist_count, ec);
          end
          beat_cnt++;
          stall = 0;
        end else begin
          stall = 1;
          sbin  = hist_bin;
          scnt  = hist_count;
        end
      end else begin
        stall = 0;
        check("idle_zero", int'(hist_bin) + int'(hist_count), 0);
      end
    end
  end

  initial begin
    int nb[8];
    int n;
    for (int k = 0; k < 8; k++) nb[k] = 100;

    rdy_mode = 0;
    apply_reset();

    // All-zero codes over a full interior scan.
    for (int i = 0; i < PIX; i++) strobe(8'h00, interior_addr(i), i == PIX - 1);
    wait_done("zeros", 0);

    // Constant-gray image: every neighbour equals the centre.
    apply_reset();
    for (int i = 0; i < PIX; i++) strobe(lbp_of(100, nb), interior_addr(i), i == PIX - 1);
    wait_done("gray", 0);

    // Back-to-back hits on one bin with a stalling consumer.
    rdy_mode = 1;
    apply_reset();
    strobe(8'd3, interior_addr(10), 0);
    strobe(8'd3, interior_addr(11), 0);
    strobe(8'd3, interior_addr(12), 0);
    strobe(8'd7, interior_addr(13), 1);
    wait_done("b2b", 0);

    // Strobe coincident with finish, random consumer.
    rdy_mode = 2;
    apply_reset();
    for (int i = 0; i < 20; i++) strobe(8'($urandom_range(0, 255)), interior_addr($urandom_range(0, PIX - 1)), 0);
    strobe(8'd9, interior_addr(500), 1);
    wait_done("same_edge", 0);

    // Random codes, gaps and addresses (including the corner), plus strobes during drain.
    apply_reset();
    strobe(8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) begin
        @(posedge clk); #1;
      end
      strobe(8'($urandom_range(0, 255)), $urandom_range(0, 16383), 0);
    end
    finish_alone();
    wait_done("random", 3);

    // Reset in the middle of draining, then a fresh pass.
    rdy_mode = 0;
    apply_reset();
    strobe(8'd1, 0, 0);
    for (int i = 0; i < 50; i++) strobe(8'($urandom_range(0, 255)), interior_addr($urandom_range(0, PIX - 1)), 0);
    finish_alone();
    for (int c = 0; c < 3000 && beat_cnt < 100; c++) @(posedge clk);
    check("reach_beat100", int'(beat_cnt >= 100), 1);
    #3;
    apply_reset();
    for (int i = 0; i < 30; i++) strobe(8'($urandom_range(0, 15)), interior_addr($urandom_range(0, PIX - 1)), i == 29);
    wait_done("after_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
